// File: rtl/auto_led_seq.sv
// Switch-pattern classifier with LED sequencing: the switches are debounced,
// the accepted result is flashed BLINK_N times, and then shown steadily until the switches change.
module auto_led_seq #(
  parameter int TICK_DIV    = 100000,
  parameter int DEB_TICKS   = 20,
  parameter int BLINK_TICKS = 250,
  parameter int BLINK_N     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] sw,
  output logic [1:0] RGB_led_A,
  output logic [1:0] code,
  output logic       valid
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int STW  = $clog2(DEB_TICKS + 1);
  localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int PHW  = $clog2(2 * BLINK_N);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [STW-1:0] STAB_DONE  = STW'(DEB_TICKS);
  localparam logic [BW-1:0]  BCNT_LAST  = BW'(BLINK_TICKS - 1);
  localparam logic [PHW-1:0] PHASE_LAST = PHW'(2 * BLINK_N - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, BLINK, SOLID} state_t;

  state_t         state, state_next;
  logic [3:0]     sw_meta, swq, swq_prev, sw_latched;
  logic [PW-1:0]  presc;
  logic [STW-1:0] stab;
  logic [BW-1:0]  bcnt;
  logic [PHW-1:0] phase;
  logic           tick, sw_changed, sw_moved, stab_done, blink_done;

  function automatic logic [1:0] classify(input logic [3:0] p);
    case (p)
      4'b1000, 4'b0010, 4'b0001, 4'b1001: classify = 2'b10;
      4'b1100, 4'b1010, 4'b1101, 4'b0011: classify = 2'b01;
      default:                            classify = 2'b00;
    endcase
  endfunction

  assign tick       = (presc == PRESC_LAST);
  assign sw_changed = (swq != swq_prev);
  assign sw_moved   = (swq != sw_latched);
  assign stab_done  = (stab == STAB_DONE);
  assign blink_done = tick && (bcnt == BCNT_LAST) && (phase == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      swq      <= '0;
      swq_prev <= '0;
      presc    <= '0;
    end else begin
      sw_meta  <= sw;
      swq      <= sw_meta;
      swq_prev <= swq;
      presc    <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Dropping en overrides every other transition.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SETTLE;
        SETTLE:  if (!sw_changed && stab_done) state_next = BLINK;
        BLINK:   if (sw_moved) state_next = SETTLE;
                 else if (blink_done) state_next = SOLID;
        SOLID:   if (sw_moved) state_next = SETTLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    valid     = 1'b0;
    RGB_led_A = 2'b00;
    case (state)
      BLINK: begin
        valid     = 1'b1;
        RGB_led_A = phase[0] ? 2'b00 : code;
      end
      SOLID: begin
        valid     = 1'b1;
        RGB_led_A = code;
      end
      default: ;
    endcase
  end

  // Counters only run while their state persists, so they restart from zero on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stab       <= '0;
      bcnt       <= '0;
      phase      <= '0;
      code       <= 2'b00;
      sw_latched <= '0;
    end else begin
      if (state == SETTLE && state_next == SETTLE) begin
        if (sw_changed)              stab <= '0;
        else if (tick && !stab_done) stab <= stab + 1'b1;
      end else begin
        stab <= '0;
      end

      if (state == SETTLE && state_next == BLINK) begin
        sw_latched <= swq;
        code       <= classify(swq);
      end

      if (state == BLINK && state_next == BLINK) begin
        if (tick) begin
          if (bcnt == BCNT_LAST) begin
            bcnt  <= '0;
            phase <= phase + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end else begin
        bcnt  <= '0;
        phase <= '0;
      end
    end
  end

endmodule
